// File: rtl/st7735_window_scheduler.sv
// -----------------------------------------------------------------------------
// st7735_window_scheduler
//
// Purpose
//   Shares an ST7735 panel between two pixel requesters once the panel init
//   sequence has completed. A round-robin arbiter picks one requester. Its
//   rectangle becomes CASET / RASET / RAMWR command bytes, and its RGB565 pixel
//   stream is then split into high/low bytes for the SPI byte transmitter.
//
// Optional feature (compile-time macro)
//   WINDOW_CACHE_EN : remembers the last completed window. If the next granted
//                     window is identical, CASET/RASET are skipped and the
//                     transaction starts directly with RAMWR (0x2C). ERR or
//                     reset invalidates the cache. When the macro is undefined,
//                     every transaction sends all 11 command/address bytes.
//
// Ports
//   i_system_clk   : single clock, all logic on posedge
//   i_system_rst   : asynchronous active-high reset
//   i_init_done    : panel init complete; no new grant while low
//   i_req[1:0]     : request per requester, sampled only in IDLE
//   i_req0_win     : {x0,y0,x1,y1} inclusive rectangle of requester 0
//   i_req1_win     : same for requester 1
//   o_gnt[1:0]     : one-hot grant, held from grant through DONE/ERR
//   i_pixN_data    : RGB565 pixel of requester N
//   i_pixN_valid   : pixel N valid
//   o_pixN_ready   : pixel N consumed this cycle (valid & ready)
//   o_tx_byte      : byte to SPI driver
//   o_tx_dc        : 0 = command, 1 = data
//   o_tx_valid     : o_tx_byte / o_tx_dc valid
//   i_tx_ready     : driver accepts when o_tx_valid & i_tx_ready
//   o_tx_last      : final byte of the transaction (driver releases CS)
//   o_done         : 1-cycle pulse, transaction finished
//   o_err          : 1-cycle pulse, window rejected
// -----------------------------------------------------------------------------
module st7735_window_scheduler #(
  parameter int LCD_WIDTH  = 128,
  parameter int LCD_HEIGHT = 160
) (
  input  logic        i_system_clk,
  input  logic        i_system_rst,
  input  logic        i_init_done,
  input  logic [1:0]  i_req,
  input  logic [31:0] i_req0_win,
  input  logic [31:0] i_req1_win,
  output logic [1:0]  o_gnt,
  input  logic [15:0] i_pix0_data,
  input  logic        i_pix0_valid,
  output logic        o_pix0_ready,
  input  logic [15:0] i_pix1_data,
  input  logic        i_pix1_valid,
  output logic        o_pix1_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_dc,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [8:0] LCD_W9 = 9'(LCD_WIDTH);
  localparam logic [8:0] LCD_H9 = 9'(LCD_HEIGHT);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_ERR,
    S_CASET_C,
    S_CASET_D,
    S_RASET_C,
    S_RASET_D,
    S_RAMWR_C,
    S_PIX_HI,
    S_PIX_LO,
    S_FIN
  } state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic        r_sel;       // index of the granted requester
  logic        r_rr;        // last winner; the other requester wins a tie
  logic [31:0] r_win;       // window latched at grant
  logic [1:0]  r_idx;       // byte index inside a 4-byte address field
  logic [14:0] r_cnt;       // pixels still to be sent
  logic [7:0]  r_tx_byte;
  logic        r_tx_dc;
  logic        r_tx_valid;
  logic        r_tx_last;
  logic        r_done;
  logic        r_err;

  // Window fields of the latched rectangle
  logic [7:0]  w_x0, w_y0, w_x1, w_y1;
  assign w_x0 = r_win[31:24];
  assign w_y0 = r_win[23:16];
  assign w_x1 = r_win[15:8];
  assign w_y1 = r_win[7:0];

  logic w_win_bad;
  assign w_win_bad = (w_x0 > w_x1) || (w_y0 > w_y1) ||
                     ({1'b0, w_x1} >= LCD_W9) || ({1'b0, w_y1} >= LCD_H9);

  // Only meaningful for a valid window, where both extents are >= 1.
  logic [8:0]  w_width, w_height;
  logic [14:0] w_npix;
  assign w_width  = {1'b0, w_x1} - {1'b0, w_x0} + 9'd1;
  assign w_height = {1'b0, w_y1} - {1'b0, w_y0} + 9'd1;
  assign w_npix   = {6'b0, w_width} * {6'b0, w_height};

  // Round robin: on a tie the requester that did not win last time goes.
  logic w_winner;
  assign w_winner = (&i_req) ? ~r_rr : i_req[1];

  logic        w_accept;
  logic        w_pix_valid;
  logic [15:0] w_pix_data;
  logic        w_hi_accept;
  assign w_accept    = r_tx_valid & i_tx_ready;
  assign w_pix_valid = r_sel ? i_pix1_valid : i_pix0_valid;
  assign w_pix_data  = r_sel ? i_pix1_data  : i_pix0_data;
  assign w_hi_accept = (r_state == S_PIX_HI) & w_accept;

  // The pixel handshake must coincide with acceptance of its high byte,
  // so ready is decoded combinationally from the registered TX state.
  logic [1:0] w_pix_ready;
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pix_ready
      assign w_pix_ready[gi] = r_gnt[gi] & w_hi_accept;
    end
  endgenerate
  assign o_pix0_ready = w_pix_ready[0];
  assign o_pix1_ready = w_pix_ready[1];

  // Address field layout: 00, lo, 00, hi
  function automatic logic [7:0] addr_byte(input logic [1:0] idx,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
    case (idx)
      2'd1:    addr_byte = lo;
      2'd3:    addr_byte = hi;
      default: addr_byte = 8'h00;
    endcase
  endfunction

  logic w_cache_hit;

`ifdef WINDOW_CACHE_EN
  logic        r_cache_valid;
  logic [31:0] r_cache_win;

  always_ff @(posedge i_system_clk or posedge i_system_rst) begin
    if (i_system_rst) begin
      r_cache_valid <= 1'b0;
      r_cache_win   <= 32'h0;
    end else if (r_state == S_FIN) begin
      r_cache_valid <= 1'b1;
      r_cache_win   <= r_win;
    end else if (r_state == S_ERR) begin
      r_cache_valid <= 1'b0;
    end
  end

  assign w_cache_hit = r_cache_valid && (r_cache_win == r_win);
`else
  assign w_cache_hit = 1'b0;
`endif

  always_ff @(posedge i_system_clk or posedge i_system_rst) begin
    if (i_system_rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'b00;
      r_sel      <= 1'b0;
      r_rr       <= 1'b1;
      r_win      <= 32'h0;
      r_idx      <= 2'd0;
      r_cnt      <= 15'd0;
      r_tx_byte  <= 8'h00;
      r_tx_dc    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_init_done && (|i_req)) begin
            r_sel   <= w_winner;
            r_rr    <= w_winner;
            r_gnt   <= w_winner ? 2'b10 : 2'b01;
            r_win   <= w_winner ? i_req1_win : i_req0_win;
            r_state <= S_CHECK;
          end
        end

        // Window is checked one cycle after grant so TX_VALID follows GNT.
        S_CHECK: begin
          if (w_win_bad) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_cnt      <= w_npix;
            r_tx_valid <= 1'b1;
            r_tx_dc    <= 1'b0;
            if (w_cache_hit) begin
              r_tx_byte <= CMD_RAMWR;
              r_state   <= S_RAMWR_C;
            end else begin
              r_tx_byte <= CMD_CASET;
              r_state   <= S_CASET_C;
            end
          end
        end

        S_ERR: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end

        S_CASET_C: begin
          if (w_accept) begin
            r_tx_byte <= 8'h00;
            r_tx_dc   <= 1'b1;
            r_idx     <= 2'd0;
            r_state   <= S_CASET_D;
          end
        end

        S_CASET_D: begin
          if (w_accept) begin
            if (r_idx == 2'd3) begin
              r_tx_byte <= CMD_RASET;
              r_tx_dc   <= 1'b0;
              r_state   <= S_RASET_C;
            end else begin
              r_tx_byte <= addr_byte(r_idx + 2'd1, w_x0, w_x1);
              r_idx     <= r_idx + 2'd1;
            end
          end
        end

        S_RASET_C: begin
          if (w_accept) begin
            r_tx_byte <= 8'h00;
            r_tx_dc   <= 1'b1;
            r_idx     <= 2'd0;
            r_state   <= S_RASET_D;
          end
        end

        S_RASET_D: begin
          if (w_accept) begin
            if (r_idx == 2'd3) begin
              r_tx_byte <= CMD_RAMWR;
              r_tx_dc   <= 1'b0;
              r_state   <= S_RAMWR_C;
            end else begin
              r_tx_byte <= addr_byte(r_idx + 2'd1, w_y0, w_y1);
              r_idx     <= r_idx + 2'd1;
            end
          end
        end

        S_RAMWR_C: begin
          if (w_accept) begin
            r_tx_valid <= 1'b0;
            r_tx_dc    <= 1'b1;
            r_state    <= S_PIX_HI;
          end
        end

        // TX_VALID stays low until the requester offers a pixel. The pixel
        // is only consumed when its high byte is accepted; the low byte is
        // captured into the TX register at that same edge.
        S_PIX_HI: begin
          if (!r_tx_valid) begin
            if (w_pix_valid) begin
              r_tx_byte  <= w_pix_data[15:8];
              r_tx_dc    <= 1'b1;
              r_tx_valid <= 1'b1;
            end
          end else if (i_tx_ready) begin
            r_tx_byte <= w_pix_data[7:0];
            r_tx_last <= (r_cnt == 15'd1);
            r_cnt     <= r_cnt - 15'd1;
            r_state   <= S_PIX_LO;
          end
        end

        S_PIX_LO: begin
          if (w_accept) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            if (r_tx_last) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_PIX_HI;
            end
          end
        end

        // DONE is visible here with GNT still high; GNT drops afterwards and
        // the following IDLE cycle separates back-to-back grants.
        S_FIN: begin
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_tx_byte  = r_tx_byte;
  assign o_tx_dc    = r_tx_dc;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_last  = r_tx_last;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_st7735_window_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for st7735_window_scheduler.
// Expected TX bytes ({dc,last,byte}) are pushed into a scoreboard queue when a
// transaction is set up and popped as the DUT hands bytes to the driver.
// -----------------------------------------------------------------------------
module tb_st7735_window_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] win0 = 32'h0;
  logic [31:0] win1 = 32'h0;
  logic [1:0]  gnt;
  logic [15:0] pix0_data = 16'h0;
  logic        pix0_valid = 1'b0;
  logic        pix0_ready;
  logic [15:0] pix1_data = 16'h0;
  logic        pix1_valid = 1'b0;
  logic        pix1_ready;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        done;
  logic        err;

  st7735_window_scheduler #(.LCD_WIDTH(128), .LCD_HEIGHT(160)) dut (
    .i_system_clk (clk),
    .i_system_rst (rst),
    .i_init_done  (init_done),
    .i_req        (req),
    .i_req0_win   (win0),
    .i_req1_win   (win1),
    .o_gnt        (gnt),
    .i_pix0_data  (pix0_data),
    .i_pix0_valid (pix0_valid),
    .o_pix0_ready (pix0_ready),
    .i_pix1_data  (pix1_data),
    .i_pix1_valid (pix1_valid),
    .o_pix1_ready (pix1_ready),
    .o_tx_byte    (tx_byte),
    .o_tx_dc      (tx_dc),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_tx_last    (tx_last),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

`ifdef WINDOW_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  exp_q[$];      // {dc, last, byte}
  logic [15:0] pix0_q[$];
  logic [15:0] pix1_q[$];
  int          ready_mode = 0; // 0: always ready, 1: random, 2: stalled
  bit          gap_en = 1'b0;
  logic [1:0]  s_gnt = 2'b00;
  logic        s_done = 1'b0;
  logic        s_err = 1'b0;
  int          n_bytes = 0;
  int          hs0_total = 0;

  // One clock: sample/score at negedge, drive at posedge + 1.
  task automatic tick();
    logic [9:0] e;
    bit hs0, hs1;
    @(negedge clk);
    s_gnt  = gnt;
    s_done = done;
    s_err  = err;
    if (tx_valid && tx_ready) begin
      n_tests++;
      n_bytes++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got dc=%0b last=%0b byte=%02h, required no byte",
                 tx_dc, tx_last, tx_byte);
      end else begin
        e = exp_q.pop_front();
        if ({tx_dc, tx_last, tx_byte} !== e) begin
          n_fail++;
          $display("FAIL tx_byte #%0d: got dc=%0b last=%0b byte=%02h, required dc=%0b last=%0b byte=%02h",
                   n_bytes, tx_dc, tx_last, tx_byte, e[9], e[8], e[7:0]);
        end
      end
    end
    hs0 = pix0_valid && pix0_ready;
    hs1 = pix1_valid && pix1_ready;
    if (hs0) begin
      void'(pix0_q.pop_front());
      hs0_total++;
    end
    if (hs1) void'(pix1_q.pop_front());
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    if (!(pix0_valid && !hs0)) begin
      if (pix0_q.size() > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
        pix0_valid = 1'b1;
        pix0_data  = pix0_q[0];
      end else begin
        pix0_valid = 1'b0;
      end
    end
    if (!(pix1_valid && !hs1)) begin
      if (pix1_q.size() > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
        pix1_valid = 1'b1;
        pix1_data  = pix1_q[0];
      end else begin
        pix1_valid = 1'b0;
      end
    end
  endtask

  task automatic push_cmds(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input bit full);
    if (full) begin
      exp_q.push_back({2'b00, 8'h2A});
      exp_q.push_back({2'b10, 8'h00});
      exp_q.push_back({2'b10, x0});
      exp_q.push_back({2'b10, 8'h00});
      exp_q.push_back({2'b10, x1});
      exp_q.push_back({2'b00, 8'h2B});
      exp_q.push_back({2'b10, 8'h00});
      exp_q.push_back({2'b10, y0});
      exp_q.push_back({2'b10, 8'h00});
      exp_q.push_back({2'b10, y1});
    end
    exp_q.push_back({2'b00, 8'h2C});
  endtask

  task automatic push_pix(input logic [15:0] p, input bit last);
    exp_q.push_back({2'b10, p[15:8]});
    exp_q.push_back({1'b1, last, p[7:0]});
  endtask

  task automatic wait_gnt(input logic [1:0] exp_g);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (s_gnt == 2'b00 && k < 200);
    n_tests++;
    if (s_gnt !== exp_g) begin
      n_fail++;
      $display("FAIL gnt: got %b after %0d cycles, required %b", s_gnt, k, exp_g);
    end
  endtask

  task automatic wait_end(input bit exp_err);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!s_done && !s_err && k < 3000);
    n_tests++;
    if ({s_done, s_err} !== {~exp_err, exp_err}) begin
      n_fail++;
      $display("FAIL txn_end: got done=%0b err=%0b, required done=%0b err=%0b",
               s_done, s_err, ~exp_err, exp_err);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bytes_left: got %0d unsent expected bytes, required 0", exp_q.size());
    end
    $display("[TB] txn end: done=%0b err=%0b gnt=%b cycles=%0d", s_done, s_err, s_gnt, k);
    tick();
    n_tests++;
    if (s_gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL gnt_release: got %b, required 00", s_gnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++;
    if ({gnt, tx_valid, tx_byte, tx_dc, tx_last, done, err, pix0_ready, pix1_ready} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b v=%0b b=%02h dc=%0b l=%0b d=%0b e=%0b, required all 0",
               gnt, tx_valid, tx_byte, tx_dc, tx_last, done, err);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({gnt, tx_valid, done, err} !== 5'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got gnt=%b v=%0b d=%0b e=%0b, required all 0", gnt, tx_valid, done, err);
    end
  endtask

  task automatic test_init_gate();
    init_done = 1'b0;
    win0 = {8'd0, 8'd0, 8'd1, 8'd0};
    pix0_q.push_back(16'hA1B2);
    pix0_q.push_back(16'hC3D4);
    req = 2'b01;
    repeat (10) tick();
    n_tests++;
    if (s_gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL init_gate: got gnt=%b, required 00", s_gnt);
    end
    push_cmds(8'd0, 8'd0, 8'd1, 8'd0, 1'b1);
    push_pix(16'hA1B2, 1'b0);
    push_pix(16'hC3D4, 1'b1);
    init_done = 1'b1;
    wait_gnt(2'b01);
    req = 2'b00;
    wait_end(1'b0);
  endtask

  task automatic test_round_robin();
    logic [15:0] p;
    do_reset();
    win0 = 32'h0;
    win1 = 32'h0;
    pix0_q.push_back(16'h1111);
    pix0_q.push_back(16'h2222);
    pix1_q.push_back(16'h3333);
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 16'h1111 : (k == 1) ? 16'h3333 : 16'h2222;
      push_cmds(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
      push_pix(p, 1'b1);
      wait_gnt((k == 1) ? 2'b10 : 2'b01);
      if (k == 2) req = 2'b00;
      wait_end(1'b0);
    end
  endtask

  task automatic test_err();
    do_reset();
    win0 = {8'd5, 8'd0, 8'd4, 8'd0};
    req = 2'b01;
    wait_gnt(2'b01);
    req = 2'b00;
    wait_end(1'b1);
    win0 = {8'd0, 8'd160, 8'd0, 8'd160};
    req = 2'b01;
    wait_gnt(2'b01);
    req = 2'b00;
    wait_end(1'b1);
  endtask

  task automatic test_stream();
    logic [15:0] px[4];
    px[0] = 16'hF800; px[1] = 16'h07E0; px[2] = 16'h001F; px[3] = 16'hFFFF;
    do_reset();
    ready_mode = 1;
    gap_en = 1'b1;
    win0 = {8'd0, 8'd0, 8'd1, 8'd1};
    push_cmds(8'd0, 8'd0, 8'd1, 8'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pix0_q.push_back(px[i]);
      push_pix(px[i], i == 3);
    end
    req = 2'b01;
    wait_gnt(2'b01);
    req = 2'b00;
    wait_end(1'b0);
    ready_mode = 0;
    gap_en = 1'b0;
  endtask

  task automatic test_back_to_back_cache();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      if (t < 2) win0 = {8'd2, 8'd3, 8'd4, 8'd3};
      else       win0 = {8'd2, 8'd3, 8'd5, 8'd3};
      push_cmds(8'd2, 8'd3, (t < 2) ? 8'd4 : 8'd5, 8'd3, !(t == 1 && CACHE_ON));
      for (int i = 0; i < ((t < 2) ? 3 : 4); i++) begin
        pix0_q.push_back(16'h0100 * 16'(t) + 16'(i));
        push_pix(16'h0100 * 16'(t) + 16'(i), i == ((t < 2) ? 2 : 3));
      end
      req = 2'b01;
      wait_gnt(2'b01);
      req = 2'b00;
      wait_end(1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int start, k;
    do_reset();
    win0 = {8'd3, 8'd4, 8'd3, 8'd4};
    pix0_q.push_back(16'hBEEF);
    push_cmds(8'd3, 8'd4, 8'd3, 8'd4, 1'b1);
    push_pix(16'hBEEF, 1'b1);
    req = 2'b01;
    wait_gnt(2'b01);
    req = 2'b00;
    start = hs0_total;
    k = 0;
    while (hs0_total == start && k < 100) begin
      tick();
      k++;
    end
    n_tests++;
    if (hs0_total == start) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got no pixel handshake in %0d cycles, required 1", k);
    end
    // Now in the low-byte state with TX_LAST set; stall and reset.
    ready_mode = 2;
    tx_ready = 1'b0;
    #2;
    n_tests++;
    if ({tx_valid, tx_last, tx_byte} !== {1'b1, 1'b1, 8'hEF}) begin
      n_fail++;
      $display("FAIL pre_reset_lo: got v=%0b l=%0b b=%02h, required v=1 l=1 b=EF", tx_valid, tx_last, tx_byte);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({gnt, tx_valid, tx_byte, tx_dc, tx_last, done, err, pix0_ready} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got gnt=%b v=%0b b=%02h dc=%0b l=%0b, required all 0",
               gnt, tx_valid, tx_byte, tx_dc, tx_last);
    end
    exp_q.delete();
    pix0_q.delete();
    pix0_valid = 1'b0;
    tick();
    rst = 1'b0;
    ready_mode = 0;
    tick();
    pix0_q.push_back(16'h1234);
    push_cmds(8'd3, 8'd4, 8'd3, 8'd4, 1'b1);
    push_pix(16'h1234, 1'b1);
    req = 2'b01;
    wait_gnt(2'b01);
    req = 2'b00;
    wait_end(1'b0);
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_round_robin();
    test_err();
    test_stream();
    test_back_to_back_cache();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
